// File: rtl/pixel_draw_scheduler_if.sv
// Command, grant/completion and pixel-output bundle between two draw requesters,
// the scheduler and the VGA adapter.
interface pixel_draw_scheduler_if;
  logic       req0;
  logic       req1;
  logic [8:0] x0_0;
  logic [8:0] x0_1;
  logic [7:0] y0_0;
  logic [7:0] y0_1;
  logic [8:0] w_0;
  logic [8:0] w_1;
  logic [7:0] h_0;
  logic [7:0] h_1;
  logic [2:0] col_0;
  logic [2:0] col_1;
  logic       gnt0;
  logic       gnt1;
  logic       done;
  logic       done_id;
  logic       busy;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (
    output req0, req1, x0_0, x0_1, y0_0, y0_1, w_0, w_1, h_0, h_1, col_0, col_1,
    input  gnt0, gnt1, done, done_id, busy, x, y, colour, plot
  );

  modport slave (
    input  req0, req1, x0_0, x0_1, y0_0, y0_1, w_0, w_1, h_0, h_1, col_0, col_1,
    output gnt0, gnt1, done, done_id, busy, x, y, colour, plot
  );
endinterface

// File: rtl/pixel_draw_scheduler.sv
// Round-robin scheduler for two rectangle-fill requesters; clips each rectangle to the
// screen and streams its pixels in raster order, one per cycle, to the VGA adapter.
module pixel_draw_scheduler #(
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240
) (
  input logic                  clock,
  input logic                  resetn,
  pixel_draw_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StDraw, StDone} state_e;

  localparam logic [9:0] ScrW = 10'(SCREEN_W);
  localparam logic [9:0] ScrH = 10'(SCREEN_H);

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic       win_q, win_d;
  logic [8:0] cx0_q, cx0_d;
  logic [7:0] cy0_q, cy0_d;
  logic [8:0] cw_q, cw_d;
  logic [7:0] ch_q, ch_d;
  logic [2:0] ccol_q, ccol_d;
  logic [9:0] x_last_q, x_last_d;
  logic [9:0] y_last_q, y_last_d;

  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done_q, done_d;
  logic       done_id_q, done_id_d;
  logic       busy_q, busy_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;

  logic       sel;
  logic [9:0] x0_ext, y0_ext, w_ext, h_ext;
  logic [9:0] room_x, room_y, ew, eh;

  // 10-bit clip math: x0+w and y0+h never wrap.
  always_comb begin
    x0_ext = {1'b0, cx0_q};
    y0_ext = {2'b0, cy0_q};
    w_ext  = {1'b0, cw_q};
    h_ext  = {2'b0, ch_q};
    room_x = ScrW - x0_ext;
    room_y = ScrH - y0_ext;
    ew     = (x0_ext >= ScrW) ? 10'd0 : ((w_ext < room_x) ? w_ext : room_x);
    eh     = (y0_ext >= ScrH) ? 10'd0 : ((h_ext < room_y) ? h_ext : room_y);
  end

  // Contention goes to the pointer; a lone request always wins.
  assign sel = (bus.req0 && bus.req1) ? rr_q : bus.req1;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    cx0_d     = cx0_q;
    cy0_d     = cy0_q;
    cw_d      = cw_q;
    ch_d      = ch_q;
    ccol_d    = ccol_q;
    x_last_d  = x_last_q;
    y_last_d  = y_last_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          state_d = StLoad;
          win_d   = sel;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          cx0_d   = sel ? bus.x0_1  : bus.x0_0;
          cy0_d   = sel ? bus.y0_1  : bus.y0_0;
          cw_d    = sel ? bus.w_1   : bus.w_0;
          ch_d    = sel ? bus.h_1   : bus.h_0;
          ccol_d  = sel ? bus.col_1 : bus.col_0;
        end
      end
      StLoad: begin
        if (ew == 10'd0 || eh == 10'd0) begin
          state_d   = StDone;
          done_d    = 1'b1;
          done_id_d = win_q;
        end else begin
          state_d  = StDraw;
          plot_d   = 1'b1;
          x_d      = cx0_q;
          y_d      = cy0_q;
          colour_d = ccol_q;
          x_last_d = x0_ext + ew - 10'd1;
          y_last_d = y0_ext + eh - 10'd1;
        end
      end
      StDraw: begin
        plot_d = 1'b1;
        if ({1'b0, x_q} == x_last_q) begin
          if ({2'b0, y_q} == y_last_q) begin
            state_d   = StDone;
            plot_d    = 1'b0;
            done_d    = 1'b1;
            done_id_d = win_q;
          end else begin
            x_d = cx0_q;
            y_d = y_q + 8'd1;
          end
        end else begin
          x_d = x_q + 9'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        rr_d    = ~win_q;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      rr_q      <= 1'b0;
      win_q     <= 1'b0;
      cx0_q     <= '0;
      cy0_q     <= '0;
      cw_q      <= '0;
      ch_q      <= '0;
      ccol_q    <= '0;
      x_last_q  <= '0;
      y_last_q  <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      busy_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      cx0_q     <= cx0_d;
      cy0_q     <= cy0_d;
      cw_q      <= cw_d;
      ch_q      <= ch_d;
      ccol_q    <= ccol_d;
      x_last_q  <= x_last_d;
      y_last_q  <= y_last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.busy    = busy_q;
  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.colour  = colour_q;
  assign bus.plot    = plot_q;

endmodule

// File: tb/tb_pixel_draw_scheduler.sv
// Scoreboard bench: expected grants, pixels and completions are queued when a command
// is issued and consumed by a negedge monitor as the scheduler produces them.
module tb_pixel_draw_scheduler;
  localparam int ScrW = 320;
  localparam int ScrH = 240;

  logic clock = 1'b0;
  logic resetn;

  pixel_draw_scheduler_if bus ();

  pixel_draw_scheduler #(
    .SCREEN_W(ScrW),
    .SCREEN_H(ScrH)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  int unsigned gnt_exp[$];
  int unsigned pix_exp[$];
  int unsigned done_exp[$];

  int cyc           = 0;
  int gnt_cyc       = 0;
  int last_done_cyc = -100;
  int plots_this    = 0;
  int granted_cmds  = 0;
  int done_cmds     = 0;
  logic prev_gnt    = 1'b0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: walk the requested rectangle and keep only on-screen pixels.
  task automatic push_cmd(input int id, input int x0, input int y0, input int w, input int h,
                          input int col);
    gnt_exp.push_back(id);
    for (int yy = y0; yy < y0 + h && yy < ScrH; yy++)
      for (int xx = x0; xx < x0 + w && xx < ScrW; xx++)
        pix_exp.push_back({12'd0, 9'(xx), 8'(yy), 3'(col)});
    done_exp.push_back(id);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (resetn) begin
      if (bus.gnt0 || bus.gnt1) begin
        check("gnt_onehot", {31'd0, bus.gnt0 && bus.gnt1}, 0);
        check("gnt_pulse", {31'd0, prev_gnt}, 0);
        check("gnt_busy", {31'd0, bus.busy}, 1);
        check("gnt_gap_ok", {31'd0, (cyc - last_done_cyc) >= 2}, 1);
        if (gnt_exp.size() == 0) check("gnt_unexpected", 1, 0);
        else check("gnt_id", {31'd0, bus.gnt1}, gnt_exp.pop_front());
        granted_cmds++;
        plots_this = 0;
        gnt_cyc    = cyc;
      end
      if (bus.plot) begin
        check("plot_in_cmd", granted_cmds, done_cmds + 1);
        if (plots_this == 0) check("first_plot_lat", cyc - gnt_cyc, 1);
        if (pix_exp.size() == 0) check("pix_unexpected", 1, 0);
        else check("pixel", {12'd0, bus.x, bus.y, bus.colour}, pix_exp.pop_front());
        plots_this++;
      end
      if (bus.done) begin
        check("done_lat", cyc - gnt_cyc, 1 + plots_this);
        if (done_exp.size() == 0) check("done_unexpected", 1, 0);
        else check("done_id", {31'd0, bus.done_id}, done_exp.pop_front());
        done_cmds++;
        last_done_cyc = cyc;
      end
      prev_gnt = bus.gnt0 || bus.gnt1;
    end else begin
      prev_gnt = 1'b0;
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(gnt_exp.size() == 0 && pix_exp.size() == 0 && done_exp.size() == 0 && !bus.busy)
           && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (n >= budget) begin
      check("idle_timeout", 0, 1);
      gnt_exp.delete();
      pix_exp.delete();
      done_exp.delete();
    end
    @(negedge clock);
    check("idle_plot", {31'd0, bus.plot}, 0);
  endtask

  task automatic drive(input int id, input int x0, input int y0, input int w, input int h,
                       input int col);
    if (id == 0) begin
      bus.x0_0 = 9'(x0); bus.y0_0 = 8'(y0); bus.w_0 = 9'(w); bus.h_0 = 8'(h);
      bus.col_0 = 3'(col); bus.req0 = 1'b1;
    end else begin
      bus.x0_1 = 9'(x0); bus.y0_1 = 8'(y0); bus.w_1 = 9'(w); bus.h_1 = 8'(h);
      bus.col_1 = 3'(col); bus.req1 = 1'b1;
    end
  endtask

  task automatic wait_gnt(input int id);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clock);
      seen = (id == 0) ? bus.gnt0 : bus.gnt1;
      n++;
    end
    if (!seen) check("gnt_timeout", 0, 1);
    if (id == 0) bus.req0 = 1'b0;
    else bus.req1 = 1'b0;
  endtask

  task automatic issue(input int id, input int x0, input int y0, input int w, input int h,
                       input int col);
    push_cmd(id, x0, y0, w, h, col);
    @(posedge clock);
    #1;
    drive(id, x0, y0, w, h, col);
    wait_gnt(id);
    wait_idle(2000);
  endtask

  initial begin
    int n;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.x0_0 = '0; bus.y0_0 = '0; bus.w_0 = '0; bus.h_0 = '0; bus.col_0 = '0;
    bus.x0_1 = '0; bus.y0_1 = '0; bus.w_1 = '0; bus.h_1 = '0; bus.col_1 = '0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #3;
    check("rst_x", bus.x, 0);
    check("rst_y", bus.y, 0);
    check("rst_colour", bus.colour, 0);
    check("rst_plot", bus.plot, 0);
    check("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
    check("rst_done", {bus.done_id, bus.done}, 0);
    check("rst_busy", bus.busy, 0);

    // Both requesters held from reset: expect 0, 1, 0, 1.
    drive(0, 5, 5, 2, 1, 1);
    drive(1, 7, 9, 1, 2, 2);
    push_cmd(0, 5, 5, 2, 1, 1);
    push_cmd(1, 7, 9, 1, 2, 2);
    push_cmd(0, 5, 5, 2, 1, 1);
    push_cmd(1, 7, 9, 1, 2, 2);
    @(posedge clock);
    #1 resetn = 1'b1;
    n = 0;
    while (granted_cmds < 4 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (n >= 200) check("arb_timeout", 0, 1);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle(500);

    issue(0, 100, 100, 6, 1, 7);
    issue(1, 10, 20, 3, 2, 3);
    issue(0, 318, 239, 5, 3, 6);
    issue(1, 330, 10, 4, 4, 2);
    issue(0, 20, 30, 0, 5, 1);
    issue(1, 20, 30, 5, 0, 1);
    issue(0, 40, 250, 3, 3, 5);
    issue(1, 300, 200, 40, 60, 4);

    // Reset in the third pixel cycle of a long command.
    push_cmd(0, 50, 50, 10, 1, 4);
    @(posedge clock);
    #1;
    drive(0, 50, 50, 10, 1, 4);
    wait_gnt(0);
    n = 0;
    while (plots_this < 2 && n < 50) begin
      @(posedge clock);
      n++;
    end
    #1 resetn = 1'b0;
    #1;
    check("midrst_plot", bus.plot, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    pix_exp.delete();
    done_exp.delete();
    gnt_exp.delete();
    done_cmds = granted_cmds;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (12) @(posedge clock);
    issue(0, 40, 30, 3, 1, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
